// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
//   state_t  : FSM state encoding (ST_IDLE, ST_SHIFT, ST_DONE)
//   MODE_ADD : mode input value selecting A+B+C_in
//   MODE_SUB : mode input value selecting A-B-C_in
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/full_adder_1b.sv
// Single-bit full adder cell, the same cell style used by parallel_adder.
// Ports:
//   a, b   : operand bits
//   c_in   : carry in
//   s      : sum bit
//   c_out  : carry out
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: computes A+B+C_in or A-B-C_in one bit per
// clock, LSB first, through one full_adder_1b cell.
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   start      : request, honoured only in IDLE or DONE
//   mode       : 0 = add, 1 = subtract (C_in acts as borrow-in)
//   A, B, C_in : operands, captured on an accepted start
//   busy       : high while bits are being shifted
//   done       : one-cycle pulse when S/C_out/overflow are updated
//   S          : WIDTH-bit result (wraps modulo 2^WIDTH)
//   C_out      : carry-out (add) or borrow-out (sub)
//   overflow   : two's-complement signed overflow
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_next;
  logic             carry;
  logic             mode_q;
  logic [CW-1:0]    bit_cnt;
  logic             fa_s;
  logic             fa_c;
  logic             accept;
  logic             last_bit;

  full_adder_1b u_fa (
    .a     (op_a[0]),
    .b     (op_b[0]),
    .c_in  (carry),
    .s     (fa_s),
    .c_out (fa_c)
  );

  assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_bit = (bit_cnt == CW'(WIDTH - 1));

  // New sum bit enters at the MSB so the result ends up LSB-aligned.
  assign result_next = (result >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start) next_state = ST_SHIFT;
      ST_SHIFT: if (last_bit) next_state = ST_DONE;
      ST_DONE:  next_state = start ? ST_SHIFT : ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Subtraction is A + ~B + ~borrow; the inversion happens once at capture
  // so the shifting datapath is identical for both modes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a     <= '0;
      op_b     <= '0;
      result   <= '0;
      carry    <= 1'b0;
      mode_q   <= MODE_ADD;
      bit_cnt  <= '0;
      S        <= '0;
      C_out    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      op_a    <= A;
      op_b    <= (mode == MODE_SUB) ? ~B : B;
      carry   <= (mode == MODE_SUB) ? ~C_in : C_in;
      mode_q  <= mode;
      bit_cnt <= '0;
    end else if (state == ST_SHIFT) begin
      result  <= result_next;
      op_a    <= op_a >> 1;
      op_b    <= op_b >> 1;
      carry   <= fa_c;
      bit_cnt <= bit_cnt + CW'(1);
      // On the last bit the carry register still holds the carry into the
      // MSB cell, so overflow is that XOR the final raw carry.
      if (last_bit) begin
        S        <= result_next;
        C_out    <= (mode_q == MODE_SUB) ? ~fa_c : fa_c;
        overflow <= carry ^ fa_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub (WIDTH=4). A timeline model derives
// busy/done timing and results from plain integer arithmetic; a compare
// process checks every cycle, and directed tests pin hand-computed values.
module tb_serial_add_sub;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic         mode;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         C_in;
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         C_out;
  logic         overflow;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;

  // Model state: cycles of busy left, expected done, held results.
  int           m_left;
  logic         m_done;
  logic [W-1:0] m_s;
  logic         m_c;
  logic         m_v;
  logic [W-1:0] p_s;
  logic         p_c;
  logic         p_v;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .A        (A),
    .B        (B),
    .C_in     (C_in),
    .busy     (busy),
    .done     (done),
    .S        (S),
    .C_out    (C_out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic: returns {overflow, carry/borrow, sum}.
  function automatic logic [W+1:0] golden(input logic m, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic cin);
    int ua, ub, sa, sb, r, sr;
    logic [W-1:0] s;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (m) begin
      r  = ua - ub - int'(cin);
      sr = sa - sb - int'(cin);
      c  = (r < 0);
    end else begin
      r  = ua + ub + int'(cin);
      sr = sa + sb + int'(cin);
      c  = (r >= (1 << W));
    end
    s = r[W-1:0];
    v = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
    return {v, c, s};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_s    <= '0;
      m_c    <= 1'b0;
      m_v    <= 1'b0;
    end else begin
      m_done <= (m_left == 1);
      if (m_left == 1) begin
        m_s <= p_s;
        m_c <= p_c;
        m_v <= p_v;
      end
      if (m_left > 0) begin
        m_left <= m_left - 1;
      end else if (start) begin
        m_left <= W;
        {p_v, p_c, p_s} <= golden(mode, A, B, C_in);
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check_output("busy", 32'(busy), 32'(m_left > 0));
      check_output("done", 32'(done), 32'(m_done));
      check_output("S", 32'(S), 32'(m_s));
      check_output("C_out", 32'(C_out), 32'(m_c));
      check_output("overflow", 32'(overflow), 32'(m_v));
    end
  end

  // Called just after a negedge: presents a one-cycle start pulse, then
  // scrambles the operand inputs to show they were latched.
  task automatic apply_stimulus(input logic m, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic cin);
    start = 1'b1;
    mode  = m;
    A     = a;
    B     = b;
    C_in  = cin;
    @(negedge clk);
    start = 1'b0;
    mode  = ~m;
    A     = ~a;
    B     = a ^ b;
    C_in  = ~cin;
  endtask

  // Waits for done, counting cycles from the negedge after the start pulse.
  task automatic wait_done(input int first, output int cycles);
    cycles = first;
    while (!done && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    if (!done) begin
      check_output("done_timeout", 32'(done), 32'd1);
    end
  endtask

  task automatic run_op(input string name, input logic m, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] es, input logic ec, input logic ev);
    int lat;
    apply_stimulus(m, a, b, cin);
    wait_done(1, lat);
    check_output({name, "_latency"}, 32'(lat), 32'd5);
    check_output({name, "_S"}, 32'(S), 32'(es));
    check_output({name, "_C_out"}, 32'(C_out), 32'(ec));
    check_output({name, "_ovf"}, 32'(overflow), 32'(ev));
    check_output({name, "_model"}, 32'({m_v, m_c, m_s}), 32'({ev, ec, es}));
  endtask

  initial begin
    int lat;
    int pulses;
    rst   = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    A     = '0;
    B     = '0;
    C_in  = 1'b0;
    #3;
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    check_output("reset_S", 32'(S), 32'd0);
    check_output("reset_flags", 32'({C_out, overflow}), 32'd0);
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);

    run_op("add_3_5", 1'b0, 4'd3, 4'd5, 1'b0, 4'h8, 1'b0, 1'b1);
    run_op("add_15_1", 1'b0, 4'd15, 4'd1, 1'b0, 4'h0, 1'b1, 1'b0);
    run_op("add_15_0_c", 1'b0, 4'd15, 4'd0, 1'b1, 4'h0, 1'b1, 1'b0);
    run_op("sub_3_5", 1'b1, 4'd3, 4'd5, 1'b0, 4'hE, 1'b1, 1'b0);
    run_op("sub_5_3_b", 1'b1, 4'd5, 4'd3, 1'b1, 4'h1, 1'b0, 1'b0);
    run_op("sub_8_1", 1'b1, 4'h8, 4'd1, 1'b0, 4'h7, 1'b0, 1'b1);

    // Back-to-back: start presented during the DONE cycle just observed.
    run_op("b2b_add_1_1", 1'b0, 4'd1, 4'd1, 1'b0, 4'h2, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    // Start pulsed while busy must be ignored.
    apply_stimulus(1'b0, 4'd2, 4'd3, 1'b0);
    start = 1'b1;
    mode  = 1'b1;
    A     = 4'd7;
    B     = 4'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(2, lat);
    check_output("ignore_latency", 32'(lat), 32'd5);
    check_output("ignore_S", 32'(S), 32'h5);
    check_output("ignore_flags", 32'({C_out, overflow}), 32'd0);
    pulses = 1;
    repeat (8) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check_output("ignore_pulses", 32'(pulses), 32'd1);

    // Asynchronous reset in the middle of a shift.
    apply_stimulus(1'b0, 4'd6, 4'd7, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_output("midrst_busy", 32'(busy), 32'd0);
    check_output("midrst_done", 32'(done), 32'd0);
    check_output("midrst_S", 32'(S), 32'd0);
    check_output("midrst_flags", 32'({C_out, overflow}), 32'd0);
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) pulses++;
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check_output("midrst_no_done", 32'(pulses), 32'd0);
    run_op("after_rst_6_7", 1'b0, 4'd6, 4'd7, 1'b0, 4'hD, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
